// File: rtl/fdiv53_seq_pkg.sv
// Shared types and constants for the iterative 53-bit mantissa divider sequencer.
package fdiv53_seq_pkg;

   localparam int STEPS_DEF = 7;
   localparam int QW = 8 * STEPS_DEF;
   localparam logic [6:0] LSHIFT_NONE = 7'(QW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      state_e          state;
      logic [2:0]      cnt;
      logic [52:0]     resid;
      logic [52:0]     divisor;
      logic [QW-1:0]   quotient;
      logic [6:0]      lshift;
      logic            found;
      logic            dbz;
   } regs_t;

endpackage

// File: rtl/fdiv53_seq_divstage.sv
// Combinational radix-256 restoring divide step: 8 quotient bits, new residual and
// the leading-zero index of the most significant quotient bit produced.
module divstage53 (
   input  logic [60:0] i_dividend,
   input  logic [52:0] i_divisor,
   input  logic        i_mux_ena,
   input  logic [55:0] i_muxind,
   output logic [7:0]  o_bits,
   output logic [52:0] o_dif,
   output logic [6:0]  o_muxind,
   output logic        o_muxind_rdy
);

   logic [60:0] rem;
   logic [60:0] sub;
   logic [7:0]  q;
   logic        unused_rem_hi;

   // Quotient is known to be < 256, so eight conditional subtractions suffice.
   always_comb begin
      rem = i_dividend;
      sub = '0;
      q   = '0;
      for (int k = 7; k >= 0; k--) begin
         sub = {8'h00, i_divisor} << k;
         if (rem >= sub) begin
            rem  = rem - sub;
            q[k] = 1'b1;
         end
      end
   end

   always_comb begin
      o_muxind = '0;
      for (int j = 0; j < 8; j++) begin
         if (q[j]) o_muxind = i_muxind[7*j +: 7];
      end
   end

   assign o_bits        = q;
   assign o_dif         = rem[52:0];
   assign o_muxind_rdy  = i_mux_ena && (q != 8'h00);
   assign unused_rem_hi = |rem[60:53];

endmodule

// File: rtl/fdiv53_seq.sv
// Sequencer driving divstage53 for STEPS cycles; packs quotient and leading-zero shift.
// Optional FDIV53_RESID_EN adds o_resid_zero (exact-quotient flag).
module fdiv53_seq
   import fdiv53_seq_pkg::*;
#(
   parameter int STEPS = STEPS_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ena,
   input  logic [52:0]       i_divident,
   input  logic [52:0]       i_divisor,
   output logic              o_ready,
   output logic              o_valid,
   output logic [8*STEPS-1:0] o_result,
   output logic [6:0]        o_lshift,
`ifdef FDIV53_RESID_EN
   output logic              o_resid_zero,
`endif
   output logic              o_dbz
);

   localparam int QWL = 8 * STEPS;
   localparam logic [6:0] LSHIFT_EMPTY = 7'(QWL);
   localparam logic [2:0] LAST_CNT = 3'(STEPS - 1);

   regs_t       r_q, r_d;
   logic [60:0] st_dividend;
   logic [55:0] st_muxind;
   logic [7:0]  st_bits;
   logic [52:0] st_dif;
   logic [6:0]  st_mux_o;
   logic        st_mux_rdy;

`ifdef FDIV53_RESID_EN
   logic rz_q, rz_d;
`endif

   always_comb begin
      st_dividend = (r_q.cnt == 3'd0) ? {8'h00, r_q.resid} : {r_q.resid, 8'h00};
      st_muxind   = '0;
      for (int j = 0; j < 8; j++) begin
         st_muxind[7*j +: 7] = 7'({r_q.cnt, 3'b000}) + 7'(7 - j);
      end
   end

   divstage53 u_stage (
      .i_dividend   (st_dividend),
      .i_divisor    (r_q.divisor),
      .i_mux_ena    (!r_q.found),
      .i_muxind     (st_muxind),
      .o_bits       (st_bits),
      .o_dif        (st_dif),
      .o_muxind     (st_mux_o),
      .o_muxind_rdy (st_mux_rdy)
   );

   always_comb begin
      r_d = r_q;
`ifdef FDIV53_RESID_EN
      rz_d = rz_q;
`endif
      case (r_q.state)
         IDLE: begin
            if (i_ena) begin
               r_d.divisor  = i_divisor;
               r_d.resid    = i_divident;
               r_d.cnt      = 3'd0;
               r_d.found    = 1'b0;
               r_d.quotient = '0;
               r_d.lshift   = 7'd0;
`ifdef FDIV53_RESID_EN
               rz_d = 1'b0;
`endif
               if (i_divisor == '0) begin
                  r_d.state    = DONE;
                  r_d.dbz      = 1'b1;
                  r_d.quotient = '1;
               end else begin
                  r_d.state = BUSY;
                  r_d.dbz   = 1'b0;
               end
            end
         end
         BUSY: begin
            r_d.quotient = {r_q.quotient[QW-9:0], st_bits};
            r_d.resid    = st_dif;
            r_d.cnt      = r_q.cnt + 3'd1;
            if (st_mux_rdy) begin
               r_d.lshift = st_mux_o;
               r_d.found  = 1'b1;
            end
            if (r_q.cnt == LAST_CNT) begin
               r_d.state = DONE;
               if (!r_q.found && !st_mux_rdy) r_d.lshift = LSHIFT_EMPTY;
`ifdef FDIV53_RESID_EN
               rz_d = (st_dif == '0);
`endif
            end
         end
         DONE:    r_d.state = IDLE;
         default: r_d.state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_q <= '0;
      else       r_q <= r_d;
   end

`ifdef FDIV53_RESID_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) rz_q <= 1'b0;
      else       rz_q <= rz_d;
   end
   assign o_resid_zero = rz_q;
`endif

   assign o_ready  = (r_q.state == IDLE);
   assign o_valid  = (r_q.state == DONE);
   assign o_result = r_q.quotient[QWL-1:0];
   assign o_lshift = r_q.lshift;
   assign o_dbz    = r_q.dbz;

endmodule

// File: tb/tb_fdiv53_seq.sv
// Self-checking bench for fdiv53_seq: arithmetic quotient model plus directed vectors.
module tb_fdiv53_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b0;
   logic [52:0] dvd = '0;
   logic [52:0] dvs = '0;
   logic        o_ready, o_valid, o_dbz;
   logic [55:0] o_result;
   logic [6:0]  o_lshift;
`ifdef FDIV53_RESID_EN
   logic        o_rz;
`endif

   localparam logic [52:0] ONE  = 53'h10000000000000;
   localparam logic [52:0] ONE5 = 53'h18000000000000;
   localparam logic [52:0] MAXM = 53'h1FFFFFFFFFFFFF;

   fdiv53_seq dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_ena        (ena),
      .i_divident   (dvd),
      .i_divisor    (dvs),
      .o_ready      (o_ready),
      .o_valid      (o_valid),
      .o_result     (o_result),
      .o_lshift     (o_lshift),
`ifdef FDIV53_RESID_EN
      .o_resid_zero (o_rz),
`endif
      .o_dbz        (o_dbz)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;
   bit chk_en = 1'b0;
   bit pending = 1'b0;
   int exp_cyc = 0;
   logic [55:0] exp_res, held_res = '0;
   logic [6:0]  exp_ls,  held_ls  = '0;
   bit          exp_dbz, held_dbz = 1'b0;
   bit          exp_rz,  held_rz  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, ncyc);
      end
   endtask

   // Quotient = floor(a * 2^48 / b); shift is leading zeros of the 56-bit quotient.
   function automatic void model(input logic [52:0] a, input logic [52:0] b,
                                 output logic [55:0] q, output logic [6:0] ls,
                                 output bit dbz, output bit rz);
      logic [127:0] num, qq, rr;
      if (b == '0) begin
         q = '1; ls = 7'd0; dbz = 1'b1; rz = 1'b0;
      end else begin
         num = {75'd0, a} << 48;
         qq  = num / {75'd0, b};
         rr  = num % {75'd0, b};
         q   = qq[55:0];
         dbz = 1'b0;
         rz  = (rr == 0);
         ls  = 7'd56;
         for (int i = 0; i < 56; i++) if (q[i]) ls = 7'(55 - i);
      end
   endfunction

   always @(negedge clk) begin
      bit ev;
      ncyc++;
      if (chk_en) begin
         ev = pending && (ncyc == exp_cyc);
         chk("valid", o_valid, ev);
         chk("ready", o_ready, !pending);
         if (ev) begin
            held_res = exp_res; held_ls = exp_ls; held_dbz = exp_dbz; held_rz = exp_rz;
            pending  = 1'b0;
         end
         if (!pending) begin
            chk("result", o_result, held_res);
            chk("lshift", o_lshift, held_ls);
            chk("dbz", o_dbz, held_dbz);
`ifdef FDIV53_RESID_EN
            chk("resid_zero", o_rz, held_rz);
`endif
         end
      end
   end

   task automatic start(input logic [52:0] a, input logic [52:0] b, input bit hold);
      int n;
      n = 0;
      do begin
         @(negedge clk); #1; n++;
      end while (!o_ready && n < 30);
      if (!o_ready) chk("ready_timeout", o_ready, 1);
      dvd = a; dvs = b; ena = 1'b1;
      model(a, b, exp_res, exp_ls, exp_dbz, exp_rz);
      exp_cyc = ncyc + ((b == '0) ? 1 : 8);
      pending = 1'b1;
      @(posedge clk); #1;
      if (!hold) ena = 1'b0;
      dvd = 53'({$urandom(), $urandom()});
      dvs = 53'({$urandom(), $urandom()});
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (pending && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (pending) begin
         chk("done_timeout", 0, 1);
         pending = 1'b0;
      end
   endtask

   initial begin
      logic [55:0] q;
      logic [6:0]  ls;
      bit          dz, rz;

      // Pin the model against hand-computed quotients.
      model(ONE, ONE, q, ls, dz, rz);
      chk("model_1_1_q", q, 56'h01000000000000);
      chk("model_1_1_ls", ls, 7'd7);
      chk("model_1_1_rz", rz, 1'b1);
      model(ONE, ONE5, q, ls, dz, rz);
      chk("model_1_15_q", q, 56'h00AAAAAAAAAAAA);
      chk("model_1_15_ls", ls, 7'd8);
      chk("model_1_15_rz", rz, 1'b0);
      model(MAXM, ONE, q, ls, dz, rz);
      chk("model_max_q", q, 56'h01FFFFFFFFFFFF);
      model(53'd0, ONE, q, ls, dz, rz);
      chk("model_zero_ls", ls, 7'd56);

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk_en = 1'b1;
      rst    = 1'b0;
      chk("rst_ready", o_ready, 1'b1);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_result", o_result, 56'h0);

      start(ONE, ONE, 1'b0);
      wait_done();
      chk("lit_1_1", o_result, 56'h01000000000000);
      chk("lit_1_1_ls", o_lshift, 7'd7);

      start(ONE, ONE5, 1'b0);
      wait_done();
      chk("lit_1_15", o_result, 56'h00AAAAAAAAAAAA);
      chk("lit_1_15_ls", o_lshift, 7'd8);

      start(ONE, 53'd0, 1'b0);
      wait_done();
      chk("lit_dbz", o_result, 56'hFFFFFFFFFFFFFF);
      chk("lit_dbz_flag", o_dbz, 1'b1);
      chk("lit_dbz_ls", o_lshift, 7'd0);

      start(53'd0, ONE, 1'b0);
      wait_done();
      chk("lit_zero", o_result, 56'h0);
      chk("lit_zero_ls", o_lshift, 7'd56);

      start(53'd0, 53'd0, 1'b0);
      wait_done();
      start(MAXM, ONE, 1'b0);
      wait_done();
      start(ONE, MAXM, 1'b0);
      wait_done();
      start(53'h1234567890ABCD, 53'h1ABCDEF0123457, 1'b0);
      wait_done();
      start(53'h0FEDCBA9876543, 53'h10000000000001, 1'b0);
      wait_done();

      // i_ena left high while busy must not disturb the running divide.
      start(MAXM, ONE5, 1'b1);
      repeat (3) @(negedge clk);
      #1 ena = 1'b0;
      wait_done();

      // Reset in the middle of a divide: abort with no valid pulse.
      start(ONE, ONE5, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b1; ena = 1'b0; pending = 1'b0;
      held_res = '0; held_ls = '0; held_dbz = 1'b0; held_rz = 1'b0;
      @(negedge clk); #1;
      rst = 1'b0;
      chk("abort_ready", o_ready, 1'b1);
      chk("abort_result", o_result, 56'h0);

      start(ONE, ONE, 1'b0);
      wait_done();
      start(53'h15555555555555, ONE5, 1'b0);
      wait_done();

      repeat (3) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
